// File: rtl/ad9648_spi_pkg.sv
// Shared types, frame layout and power-up register table for the AD9648 SPI sequencer.
// The last table entry must stay the transfer-update write (0x0FF = 0x01).
package ad9648_spi_pkg;

    localparam int ADDR_W = 13;
    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_START     = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_GAP       = 3'd4
    } state_e;

    // 24-bit instruction + data frame as shifted out MSB first
    typedef struct packed {
        logic              rw;
        logic [1:0]        w;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } spi_frame_t;

    localparam int INIT_LEN = 8;

    localparam spi_frame_t INIT_TABLE [INIT_LEN] = '{
        '{1'b0, 2'b00, 13'h000, 8'h3C},
        '{1'b0, 2'b00, 13'h005, 8'h03},
        '{1'b0, 2'b00, 13'h008, 8'h00},
        '{1'b0, 2'b00, 13'h014, 8'h01},
        '{1'b0, 2'b00, 13'h015, 8'h00},
        '{1'b0, 2'b00, 13'h016, 8'h00},
        '{1'b0, 2'b00, 13'h017, 8'h00},
        '{1'b0, 2'b00, 13'h0FF, 8'h01}
    };

    function automatic spi_frame_t write_frame(input logic [ADDR_W-1:0] waddr,
                                               input logic [DATA_W-1:0] wdata);
        write_frame = '{rw: 1'b0, w: 2'b00, addr: waddr, data: wdata};
    endfunction

    // Out-of-range indices read as an all-zero frame rather than wrapping
    function automatic spi_frame_t init_entry(input logic [5:0] idx);
        init_entry = '0;
        for (int k = 0; k < INIT_LEN; k++) begin
            if (idx == 6'(k)) begin
                init_entry = INIT_TABLE[k];
            end
        end
    endfunction

endpackage

// File: rtl/ad9648_spi_sequencer_spi_gap_timer.sv
// Loadable down-counter; expired is high whenever the count sits at zero.
// Shared by the chip-select gap and the optional done watchdog.
module spi_gap_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         expired
);

    logic [W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && count != '0) begin
            count <= count - W'(1);
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/ad9648_spi_sequencer.sv
// Walks the AD9648 init table, then serves single host register writes over the SPI frame engine.
// Optional watchdog on spi_done_i: define AD9648_SPI_SEQ_TIMEOUT_EN.
module ad9648_spi_sequencer
    import ad9648_spi_pkg::*;
#(
    parameter int NUM_CMDS       = INIT_LEN,
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk_i,
    input  logic              rst_clk_n_i,
    input  logic              init_start_i,
    input  logic              host_req_i,
    input  logic [ADDR_W-1:0] host_addr_i,
    input  logic [DATA_W-1:0] host_data_i,
    output logic              host_ack_o,
    output logic              spi_start_o,
    output logic [23:0]       spi_word_o,
    input  logic              spi_done_i,
    output logic              init_done_o,
    output logic              busy_o,
    output logic              err_o,
    output logic [5:0]        cmd_idx_o
);

    localparam logic [2:0] IDLE      = ST_IDLE;
    localparam logic [2:0] LOAD      = ST_LOAD;
    localparam logic [2:0] START     = ST_START;
    localparam logic [2:0] WAIT_DONE = ST_WAIT_DONE;
    localparam logic [2:0] GAP       = ST_GAP;

    localparam int         TIMER_MAX = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
    localparam int         TIMER_W   = $clog2(TIMER_MAX + 1);
    localparam logic [5:0] LAST_IDX  = 6'(NUM_CMDS - 1);

    logic [2:0]         state;
    logic               src_host;
    logic [5:0]         idx;
    spi_frame_t         word;
    logic               init_done;
    logic               tmr_load;
    logic               tmr_en;
    logic [TIMER_W-1:0] tmr_load_val;
    logic               tmr_expired;
    logic               wd_timeout;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        tmr_load     = (state == WAIT_DONE) && spi_done_i;
        tmr_load_val = TIMER_W'(GAP_CYCLES);
        tmr_en       = (state == GAP);
`ifdef AD9648_SPI_SEQ_TIMEOUT_EN
        if (state == START) begin
            tmr_load     = 1'b1;
            tmr_load_val = TIMER_W'(TIMEOUT_CYCLES - 1);
        end
        tmr_en = (state == GAP) || (state == WAIT_DONE);
`endif
    end

    spi_gap_timer #(
        .W (TIMER_W)
    ) u_timer (
        .clk      (clk_i),
        .rst_n    (rst_clk_n_i),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .en       (tmr_en),
        .expired  (tmr_expired)
    );

`ifdef AD9648_SPI_SEQ_TIMEOUT_EN
    logic err;

    assign wd_timeout = (state == WAIT_DONE) && !spi_done_i && tmr_expired;

    always_ff @(posedge clk_i or negedge rst_clk_n_i) begin
        if (!rst_clk_n_i) begin
            err <= 1'b0;
        end else if (wd_timeout) begin
            err <= 1'b1;
        end
    end

    assign err_o = err;
`else
    assign wd_timeout = 1'b0;
    assign err_o      = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_clk_n_i) begin
        if (!rst_clk_n_i) begin
            state     <= IDLE;
            src_host  <= 1'b0;
            idx       <= '0;
            word      <= '0;
            init_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // Init wins over a simultaneous host request
                    if (init_start_i && !init_done) begin
                        src_host <= 1'b0;
                        idx      <= '0;
                        state    <= LOAD;
                    end else if (host_req_i && init_done) begin
                        src_host <= 1'b1;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    word  <= src_host ? write_frame(host_addr_i, host_data_i) : init_entry(idx);
                    state <= START;
                end
                START: begin
                    state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (spi_done_i) begin
                        state <= GAP;
                    end else if (wd_timeout) begin
                        state <= IDLE;
                    end
                end
                GAP: begin
                    if (tmr_expired) begin
                        if (src_host) begin
                            state <= IDLE;
                        end else if (idx < LAST_IDX) begin
                            idx   <= idx + 6'd1;
                            state <= LOAD;
                        end else begin
                            init_done <= 1'b1;
                            state     <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Ack lands in the very cycle the engine reports done (or the watchdog fires)
    assign host_ack_o  = src_host && (state == WAIT_DONE) && (spi_done_i || wd_timeout);
    assign spi_start_o = (state == START);
    assign spi_word_o  = word;
    assign init_done_o = init_done;
    assign busy_o      = (state != IDLE);
    assign cmd_idx_o   = idx;

endmodule

// File: tb/tb_ad9648_spi_sequencer.sv
// Scoreboard bench for ad9648_spi_sequencer: stimulus queues expected frames, a monitor checks them.
module tb_ad9648_spi_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        init_start = 1'b0;
    logic        host_req = 1'b0;
    logic [12:0] host_addr = '0;
    logic [7:0]  host_data = '0;
    logic        spi_done = 1'b0;
    logic        host_ack;
    logic        spi_start;
    logic [23:0] spi_word;
    logic        init_done;
    logic        busy;
    logic        err;
    logic [5:0]  cmd_idx;

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;
    int acks_seen = 0;
    int acks_expected = 0;
    int spur_issued = 0;
    int spur_served = 0;
    int eng_cnt = 0;
    int t0 = 0;
    logic prev_start = 1'b0;

    logic [23:0] exp_q[$];
    int          start_cyc[$];

    // Hand-assembled frames: {0, 00, addr[12:0], data[7:0]}
    localparam logic [23:0] TABLE_WORDS [8] = '{
        24'h00003C, 24'h000503, 24'h000800, 24'h001401,
        24'h001500, 24'h001600, 24'h001700, 24'h00FF01
    };

    ad9648_spi_sequencer dut (
        .clk_i        (clk),
        .rst_clk_n_i  (rst_n),
        .init_start_i (init_start),
        .host_req_i   (host_req),
        .host_addr_i  (host_addr),
        .host_data_i  (host_data),
        .host_ack_o   (host_ack),
        .spi_start_o  (spi_start),
        .spi_word_o   (spi_word),
        .spi_done_i   (spi_done),
        .init_done_o  (init_done),
        .busy_o       (busy),
        .err_o        (err),
        .cmd_idx_o    (cmd_idx)
    );

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // SPI engine model: done pulses 10 cycles after each start; also serves spurious-done requests
    initial forever begin
        @(negedge clk);
        spi_done = 1'b0;
        if (!rst_n) begin
            eng_cnt = 0;
        end else begin
            if (eng_cnt > 0) begin
                eng_cnt--;
                if (eng_cnt == 0) spi_done = 1'b1;
            end else if (spur_served != spur_issued) begin
                spi_done = 1'b1;
                spur_served++;
            end
            if (spi_start) eng_cnt = 10;
        end
    end

    // Monitor: pops the scoreboard on every start, validates every ack
    initial forever begin
        @(negedge clk);
        #1;
        if (rst_n) begin
            if (spi_start) begin
                check("start_single_cycle", prev_start, 1'b0);
                start_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_start: word 0x%06h issued, no frame expected", spi_word);
                end else begin
                    check("frame_word", spi_word, exp_q.pop_front());
                end
            end
            if (host_ack) begin
                acks_seen++;
                check("ack_with_done", spi_done, 1'b1);
                check("ack_after_init", init_done, 1'b1);
            end
        end
        prev_start = spi_start;
    end

    task automatic pulse_init();
        @(negedge clk);
        init_start = 1'b1;
        t0 = cyc;
        @(negedge clk);
        init_start = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int limit);
        int i = 0;
        while (busy && i < limit) begin
            @(negedge clk);
            i++;
        end
        check(name, busy, 1'b0);
    endtask

    task automatic wait_ack(input string name, input int target, input int limit);
        int i = 0;
        while (acks_seen < target && i < limit) begin
            @(negedge clk);
            #2;
            i++;
        end
        check(name, acks_seen >= target, 1'b1);
    endtask

    task automatic push_table();
        for (int k = 0; k < 8; k++) exp_q.push_back(TABLE_WORDS[k]);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_spi_start", spi_start, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_init_done", init_done, 1'b0);
        check("rst_cmd_idx", cmd_idx, 6'd0);
        check("rst_spi_word", spi_word, 24'h0);
        check("rst_host_ack", host_ack, 1'b0);
        check("rst_err", err, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Spurious done while idle
        spur_issued++;
        repeat (6) @(negedge clk);
        check("idle_spur_busy", busy, 1'b0);
        check("idle_spur_idx", cmd_idx, 6'd0);

        // Full init walk
        start_cyc.delete();
        push_table();
        pulse_init();
        for (int i = 0; i < 400 && !init_done; i++) @(negedge clk);
        check("init_done_set", init_done, 1'b1);
        check("init_busy_clear", busy, 1'b0);
        check("init_last_idx", cmd_idx, 6'd7);
        check("init_word_held", spi_word, 24'h00FF01);
        check("init_frames_left", exp_q.size(), 0);
        check("init_start_count", start_cyc.size(), 8);
        if (start_cyc.size() == 8) begin
            check("init_first_latency", start_cyc[0] - t0, 2);
            for (int k = 1; k < 8; k++) check("init_spacing", start_cyc[k] - start_cyc[k-1], 17);
        end

        // Init strobe after completion is ignored
        pulse_init();
        check("reinit_ignored_busy", busy, 1'b0);
        repeat (20) @(negedge clk);
        check("reinit_no_start", start_cyc.size(), 8);
        check("reinit_idx", cmd_idx, 6'd7);

        // Host write, with a spurious done injected during its gap
        host_addr = 13'h014;
        host_data = 8'h21;
        exp_q.push_back(24'h001421);
        acks_expected++;
        @(negedge clk);
        host_req = 1'b1;
        wait_ack("host_ack_arrived", acks_expected, 100);
        host_req = 1'b0;
        check("host_word", spi_word, 24'h001421);
        spur_issued++;
        wait_idle("host_back_idle", 50);
        repeat (10) @(negedge clk);
        check("host_ack_count", acks_seen, acks_expected);
        check("host_frames_left", exp_q.size(), 0);
        check("host_gap_spur_busy", busy, 1'b0);
        check("host_idx_kept", cmd_idx, 6'd7);

        // Plain reset clears the sticky init flag
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("reset_clears_init_done", init_done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Async reset while waiting for done on entry 3
        start_cyc.delete();
        push_table();
        pulse_init();
        for (int i = 0; i < 200 && start_cyc.size() < 4; i++) @(negedge clk);
        check("midrst_reached_entry3", start_cyc.size() >= 4, 1'b1);
        repeat (3) @(negedge clk);
        check("midrst_pre_idx", cmd_idx, 6'd3);
        check("midrst_pre_busy", busy, 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_spi_start", spi_start, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_idx", cmd_idx, 6'd0);
        check("midrst_word", spi_word, 24'h0);
        check("midrst_init_done", init_done, 1'b0);
        check("midrst_ack", host_ack, 1'b0);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Host request raised before init: held off, then served once after init
        host_addr = 13'h008;
        host_data = 8'h05;
        host_req = 1'b1;
        repeat (5) @(negedge clk);
        check("early_req_held_busy", busy, 1'b0);
        check("early_req_no_ack", acks_seen, acks_expected);
        start_cyc.delete();
        push_table();
        exp_q.push_back(24'h000805);
        acks_expected++;
        pulse_init();
        wait_ack("early_ack_arrived", acks_expected, 600);
        host_req = 1'b0;
        wait_idle("early_back_idle", 50);
        repeat (10) @(negedge clk);
        check("early_init_done", init_done, 1'b1);
        check("early_start_count", start_cyc.size(), 9);
        check("early_frames_left", exp_q.size(), 0);
        check("early_ack_count", acks_seen, acks_expected);
        check("early_idx", cmd_idx, 6'd7);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL global_timeout: bench did not complete within 20000 cycles");
        $fatal(1, "bench timeout");
    end

endmodule

// File: doc/ad9648_spi_sequencer.md
Name: ad9648_spi_sequencer

Overview:
Controller that sequences register writes to the AD9648 over the existing SPI chip-select/shift path. After reset and an init strobe, it walks a constant configuration table and issues one 24-bit SPI frame per entry. Each frame is followed by a programmable chip-select-high gap. Once init completes, it accepts single host write requests. It sits between the top-level control logic and the SPI frame engine; the engine asserts chip select on start and releases it on done.

Parameters:
- NUM_CMDS, 8, number of entries in the init table; must be 1..64.
- GAP_CYCLES, 4, idle clk_i cycles between frames (CS high time); must be ≥1.
- TIMEOUT_CYCLES, 1024, watchdog limit while waiting for spi_done_i. Used only with the optional feature.

Ports:
- clk_i  in  1  system clock.
- rst_clk_n_i  in  1  asynchronous, active-low reset.
- init_start_i  in  1  one-cycle pulse; starts the init table walk.
- host_req_i  in  1  host write request; held high until ack.
- host_addr_i  in  13  host register address.
- host_data_i  in  8  host register data.
- host_ack_o  out  1  one-cycle pulse when the host frame completes.
- spi_start_o  out  1  one-cycle pulse to the SPI engine (becomes its start_transfer).
- spi_word_o  out  24  frame: [23]=0 (write), [22:21]=00 (1 byte), [20:8]=addr, [7:0]=data.
- spi_done_i  in  1  one-cycle pulse from the engine at end of frame.
- init_done_o  out  1  sticky high once the last table entry completes.
- busy_o  out  1  high in any state except IDLE.
- err_o  out  1  sticky error flag (optional feature only; otherwise tied 0).
- cmd_idx_o  out  6  index of the current or last table entry.

Behaviour:
- Reset values: all outputs 0; state IDLE; index 0; counters 0.
- Reset mid-operation: immediate return to IDLE, spi_start_o 0. The SPI engine is reset by the same source.
- FSM states: IDLE, LOAD, START, WAIT_DONE, GAP.
- IDLE:
  - init_start_i while init_done_o=0 → LOAD with source=TABLE, index 0.
  - Else host_req_i while init_done_o=1 → LOAD with source=HOST.
  - init_start_i while init_done_o=1 is ignored.
  - host_req_i before init completes is held off: no ack until init finishes.
- LOAD: register spi_word_o from the table entry or the host inputs → START. spi_word_o stays stable until the next LOAD.
- START: spi_start_o=1 for exactly one cycle → WAIT_DONE. Latency from init_start_i to first spi_start_o is 2 cycles.
- WAIT_DONE: spi_done_i → GAP with the gap counter cleared. If source=HOST, host_ack_o pulses in the same cycle spi_done_i is seen.
- GAP: count GAP_CYCLES, then:
  - source=TABLE and index<NUM_CMDS-1 → increment index, LOAD.
  - source=TABLE and last entry → init_done_o=1, IDLE.
  - source=HOST → IDLE.
- spi_done_i outside WAIT_DONE is ignored.
- The host request is sampled only in IDLE, so a request made during GAP is served after the gap.
- Priority in IDLE: init over host.
- cmd_idx_o holds the last index after init; it does not wrap.
- The last table entry must be the transfer-update write (addr 0x0FF, data 0x01). This is enforced by package content, not by logic.

Optional Feature:
- Macro: AD9648_SPI_SEQ_TIMEOUT_EN.
- With the macro: a watchdog counter runs in WAIT_DONE. On reaching TIMEOUT_CYCLES without spi_done_i:
  - err_o is set (sticky until reset);
  - a pending host request is acked with host_ack_o;
  - the FSM goes to IDLE;
  - an aborted init leaves init_done_o=0, and a new init_start_i restarts from index 0.
- Without the macro: no counter is built, err_o is tied 0, and WAIT_DONE waits indefinitely.

Decomposition:
- Package ad9648_spi_pkg holds:
  - the state enum type;
  - the spi frame struct (rw, w, addr, data);
  - the ADDR_W=13 and DATA_W=8 constants;
  - the init table constant array (default 8 entries ending with 0x0FF=0x01).
- One natural sub-module: spi_gap_timer, a down-counter with load/expire, shared by the gap and optional timeout counts.

Test Plan:
- Init walk: pulse init_start_i; the engine model returns done 10 cycles after each start → 8 spi_start_o pulses with spi_word_o equal to table entries in order, start-to-start spacing 10+GAP+3 cycles, init_done_o high after the last gap, cmd_idx_o=7.
- Host write: after init, host_req_i with addr 0x014, data 0x21 → spi_word_o=0x001421, one spi_start_o, and host_ack_o on the done cycle.
- Early host request: host_req_i asserted during init → no ack until init_done_o=1, then exactly one host frame.
- Async reset in WAIT_DONE at entry 3 → outputs 0 immediately; a following init_start_i restarts at entry 0.
- Spurious spi_done_i in IDLE and GAP → no state change and no extra starts.
- With AD9648_SPI_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=16, withhold done → err_o high after 16 cycles, FSM back in IDLE, init_done_o=0.
